// File: rtl/keypad_responder_if.sv
// Signal bundle between a keypad scanner/test driver (master) and the
// keypad_responder matrix emulator (slave).
interface keypad_responder_if;
    logic [2:0]  column;
    logic        press_req;
    logic [3:0]  press_key;
    logic [15:0] hold_cycles;
    logic [2:0]  row;
    logic        busy;
    logic        done;
    logic        err;
    logic [7:0]  press_count;

    modport master (
        output column, press_req, press_key, hold_cycles,
        input  row, busy, done, err, press_count
    );

    modport slave (
        input  column, press_req, press_key, hold_cycles,
        output row, busy, done, err, press_count
    );
endinterface

// File: rtl/keypad_responder.sv
// Emulates one key of a 3x3 matrix keypad being pressed, held and released.
// Define KEYPAD_RESPONDER_BOUNCE_EN to add contact-bounce phases around the hold.
module keypad_responder #(
    parameter int BOUNCE_CYCLES = 16,
    parameter int TOGGLE_DIV    = 4
) (
    input logic                CLOCK_50,
    input logic                reset,
    keypad_responder_if.slave  kp
);

    typedef enum logic [1:0] {IDLE, BOUNCE_IN, HELD, BOUNCE_OUT} state_t;

    localparam logic [15:0] BOUNCE_LAST = 16'((BOUNCE_CYCLES > 1) ? BOUNCE_CYCLES - 1 : 0);
    localparam logic [15:0] TOGGLE_LAST = 16'((TOGGLE_DIV > 1) ? TOGGLE_DIV - 1 : 0);

    state_t      state_q, state_d;
    logic [3:0]  key_q, key_d;
    logic [15:0] hold_q, hold_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] tog_q, tog_d;
    logic        phase_q, phase_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic [7:0]  press_count_q, press_count_d;

    logic [15:0] hold_last;
    logic        contact;
    logic [1:0]  key_row, key_col;
    logic [2:0]  col_mask;
    logic [2:0]  row_v;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // A latched hold of zero still gives one solid-contact clock.
    assign hold_last = (hold_q == 16'd0) ? 16'd0 : hold_q - 16'd1;

    always_comb begin
        state_d       = state_q;
        key_d         = key_q;
        hold_d        = hold_q;
        cnt_d         = sat_inc(cnt_q);
        tog_d         = sat_inc(tog_q);
        phase_d       = phase_q;
        done_d        = 1'b0;
        err_d         = 1'b0;
        press_count_d = press_count_q;

        case (state_q)
            IDLE: begin
                cnt_d   = '0;
                tog_d   = '0;
                phase_d = 1'b0;
                if (kp.press_req) begin
                    if (kp.press_key <= 4'd8) begin
                        key_d  = kp.press_key;
                        hold_d = kp.hold_cycles;
`ifdef KEYPAD_RESPONDER_BOUNCE_EN
                        state_d = BOUNCE_IN;
`else
                        state_d = HELD;
`endif
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            BOUNCE_IN, BOUNCE_OUT: begin
                if (tog_q >= TOGGLE_LAST) begin
                    tog_d   = '0;
                    phase_d = ~phase_q;
                end
                if (cnt_q >= BOUNCE_LAST) begin
                    cnt_d   = '0;
                    tog_d   = '0;
                    phase_d = 1'b0;
                    if (state_q == BOUNCE_IN) begin
                        state_d = HELD;
                    end else begin
                        state_d       = IDLE;
                        done_d        = 1'b1;
                        press_count_d = press_count_q + 8'd1;
                    end
                end
            end
            HELD: begin
                if (cnt_q >= hold_last) begin
                    cnt_d   = '0;
                    tog_d   = '0;
                    phase_d = 1'b0;
`ifdef KEYPAD_RESPONDER_BOUNCE_EN
                    state_d = BOUNCE_OUT;
`else
                    state_d       = IDLE;
                    done_d        = 1'b1;
                    press_count_d = press_count_q + 8'd1;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            key_q         <= '0;
            hold_q        <= '0;
            cnt_q         <= '0;
            tog_q         <= '0;
            phase_q       <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
            press_count_q <= '0;
        end else begin
            state_q       <= state_d;
            key_q         <= key_d;
            hold_q        <= hold_d;
            cnt_q         <= cnt_d;
            tog_q         <= tog_d;
            phase_q       <= phase_d;
            done_q        <= done_d;
            err_q         <= err_d;
            press_count_q <= press_count_d;
        end
    end

    // Bounce phases start closed; phase flips every TOGGLE_DIV clocks.
    always_comb begin
        case (state_q)
            HELD:                  contact = 1'b1;
            BOUNCE_IN, BOUNCE_OUT: contact = ~phase_q;
            default:               contact = 1'b0;
        endcase
    end

    always_comb begin
        key_row = 2'd0;
        key_col = 2'd0;
        case (key_q)
            4'd0: begin key_row = 2'd0; key_col = 2'd0; end
            4'd1: begin key_row = 2'd0; key_col = 2'd1; end
            4'd2: begin key_row = 2'd0; key_col = 2'd2; end
            4'd3: begin key_row = 2'd1; key_col = 2'd0; end
            4'd4: begin key_row = 2'd1; key_col = 2'd1; end
            4'd5: begin key_row = 2'd1; key_col = 2'd2; end
            4'd6: begin key_row = 2'd2; key_col = 2'd0; end
            4'd7: begin key_row = 2'd2; key_col = 2'd1; end
            4'd8: begin key_row = 2'd2; key_col = 2'd2; end
            default: begin key_row = 2'd0; key_col = 2'd0; end
        endcase
    end

    always_comb begin
        col_mask = 3'b001 << key_col;
        row_v    = 3'b000;
        if (contact && ((kp.column & col_mask) != 3'b000))
            row_v = 3'b001 << key_row;
    end

    assign kp.row         = row_v;
    assign kp.busy        = (state_q != IDLE);
    assign kp.done        = done_q;
    assign kp.err         = err_q;
    assign kp.press_count = press_count_q;

endmodule

// File: tb/tb_keypad_responder.sv
// Randomized bench for keypad_responder against a press-sequence model that
// expands each accepted press into its per-clock expected contact values.
module tb_keypad_responder;

    logic CLOCK_50 = 1'b0;
    logic reset;

    keypad_responder_if kp ();

    keypad_responder dut (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .kp       (kp)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

`ifdef KEYPAD_RESPONDER_BOUNCE_EN
    localparam int BOUNCE = 16;
`else
    localparam int BOUNCE = 0;
`endif
    localparam int TDIV = 4;

    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: q holds the contact level for each remaining busy clock.
    bit q[$];
    bit m_busy, m_done, m_err;
    int m_count, m_key;

    int busy_seen, done_seen, err_seen, idle_seen;

    function automatic void model_reset();
        q.delete();
        m_busy  = 1'b0;
        m_done  = 1'b0;
        m_err   = 1'b0;
        m_count = 0;
    endfunction

    function automatic void model_edge();
        int h;
        if (!reset) begin
            model_reset();
            return;
        end
        m_done = 1'b0;
        m_err  = 1'b0;
        if (m_busy) begin
            void'(q.pop_front());
            if (q.size() == 0) begin
                m_busy  = 1'b0;
                m_done  = 1'b1;
                m_count = (m_count + 1) % 256;
            end
        end else if (kp.press_req) begin
            if (kp.press_key <= 4'd8) begin
                m_key = int'(kp.press_key);
                h = (kp.hold_cycles == 16'd0) ? 1 : int'(kp.hold_cycles);
                for (int i = 0; i < BOUNCE; i++) q.push_back(((i / TDIV) % 2) == 0);
                for (int i = 0; i < h; i++) q.push_back(1'b1);
                for (int i = 0; i < BOUNCE; i++) q.push_back(((i / TDIV) % 2) == 0);
                m_busy = 1'b1;
            end else begin
                m_err = 1'b1;
            end
        end
    endfunction

    function automatic logic [2:0] exp_row();
        int r, c;
        if (!m_busy || !q[0]) return 3'b000;
        r = m_key / 3;
        c = m_key % 3;
        return kp.column[c] ? 3'(1 << r) : 3'b000;
    endfunction

    task automatic check_outputs();
        check_val("row", kp.row, exp_row());
        check_val("busy", kp.busy, m_busy);
        check_val("done", kp.done, m_done);
        check_val("err", kp.err, m_err);
        check_val("press_count", kp.press_count, m_count[7:0]);
    endtask

    // Checks at the falling edge, advances the model at the rising edge.
    task automatic step();
        @(negedge CLOCK_50);
        check_outputs();
        if (kp.busy) busy_seen++;
        if (kp.done) done_seen++;
        if (kp.err) err_seen++;
        if (!kp.busy && !kp.done) idle_seen++;
        @(posedge CLOCK_50);
        model_edge();
        #1;
    endtask

    task automatic clear_tally();
        busy_seen = 0;
        done_seen = 0;
        err_seen  = 0;
        idle_seen = 0;
    endtask

    task automatic press(input int key, input int hold, input logic [2:0] col);
        kp.press_key   = 4'(key);
        kp.hold_cycles = 16'(hold);
        kp.column      = col;
        kp.press_req   = 1'b1;
        step();
        kp.press_req   = 1'b0;
    endtask

    task automatic timed_press(input string tag, input int key, input int hold, input logic [2:0] col);
        int h;
        h = (hold == 0) ? 1 : hold;
        clear_tally();
        press(key, hold, col);
        repeat (2 * BOUNCE + h + 4) step();
        check_val({tag, "_busy_len"}, busy_seen, 2 * BOUNCE + h);
        check_val({tag, "_done_cnt"}, done_seen, 1);
    endtask

    initial begin
        kp.column      = 3'b111;
        kp.press_req   = 1'b0;
        kp.press_key   = 4'd0;
        kp.hold_cycles = 16'd0;
        reset          = 1'b1;
        model_reset();
        clear_tally();
        #2 reset = 1'b0;

        // Held in reset: outputs zero, requests ignored.
        repeat (2) step();
        kp.press_req = 1'b1;
        kp.press_key = 4'd4;
        kp.hold_cycles = 16'd3;
        repeat (2) step();
        reset = 1'b1;

        // First edge after reset accepts; then reset lands 3 clocks into HELD.
        press(2, 20, 3'b100);
        repeat (BOUNCE + 3) step();
        reset = 1'b0;
        model_reset();
        #1;
        check_val("rst_row", kp.row, 3'b000);
        check_val("rst_busy", kp.busy, 1'b0);
        check_val("rst_count", kp.press_count, 8'd0);
        repeat (3) step();
        reset = 1'b1;
        clear_tally();
        repeat (30) step();
        check_val("rst_no_done", done_seen, 0);

        timed_press("k4h10", 4, 10, 3'b010);
        timed_press("k0h5", 0, 5, 3'b001);
        timed_press("k8h0", 8, 0, 3'b100);

        // Invalid keys.
        clear_tally();
        press(9, 4, 3'b111);
        repeat (3) step();
        press(15, 4, 3'b111);
        repeat (3) step();
        check_val("err_cnt", err_seen, 2);
        check_val("err_busy", busy_seen, 0);

        // Key 7 with a column sweep, including non-one-hot patterns.
        press(7, 12, 3'b001);
        for (int i = 0; i < 2 * BOUNCE + 14; i++) begin
            case (i % 5)
                0: kp.column = 3'b001;
                1: kp.column = 3'b010;
                2: kp.column = 3'b100;
                3: kp.column = 3'b011;
                default: kp.column = 3'b110;
            endcase
            step();
        end

        // Random traffic, including requests and key changes mid-press.
        for (int i = 0; i < 1500; i++) begin
            kp.press_req   = ($urandom_range(0, 3) == 0);
            kp.press_key   = 4'($urandom_range(0, 11));
            kp.hold_cycles = 16'($urandom_range(0, 12));
            kp.column      = 3'($urandom_range(0, 7));
            step();
        end
        kp.press_req = 1'b0;
        repeat (2 * BOUNCE + 16) step();

        // 256 back-to-back presses from a cleared count.
        reset = 1'b0;
        model_reset();
        step();
        reset = 1'b1;
        kp.column      = 3'b111;
        kp.press_req   = 1'b1;
        kp.press_key   = 4'd1;
        kp.hold_cycles = 16'd1;
        step();
        clear_tally();
        for (int i = 0; i < 256 * (2 * BOUNCE + 8) && done_seen < 256; i++) begin
            kp.press_key   = 4'($urandom_range(0, 8));
            kp.hold_cycles = 16'($urandom_range(0, 3));
            step();
        end
        kp.press_req = 1'b0;
        check_val("b2b_done", done_seen, 256);
        check_val("b2b_gap", idle_seen, 0);
        check_val("b2b_wrap", kp.press_count, 8'd0);
        repeat (2 * BOUNCE + 8) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
